// File: rtl/spad_pkg.sv
// rtl/spad_pkg.sv - shared types and default widths for the scratchpad sequencer
package spad_pkg;

  localparam int SPAD_DATA_W = 16;
  localparam int SPAD_ADDR_W = 9;
  localparam int SPAD_REP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } spad_state_e;

  // One skid-buffer entry: a read word plus the tags issued with it.
  typedef struct packed {
    logic [SPAD_DATA_W-1:0] data;
    logic                   pass_last;
    logic                   last;
  } skid_entry_t;

endpackage

// File: rtl/spad_rd_skid.sv
// rtl/spad_rd_skid.sv - 2-entry FIFO holding scratchpad read words under backpressure
module spad_rd_skid
  import spad_pkg::*;
#(
  parameter int W = SPAD_DATA_W + 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [1:0]   o_occ,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_occ;
  logic         w_push;
  logic         w_pop;

  // A pop frees a slot in the same cycle, so push into a full buffer is legal when popping.
  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rptr];

endmodule

// File: rtl/spad_seq.sv
// rtl/spad_seq.sv - fill/replay sequencer for one PE scratchpad
module spad_seq
  import spad_pkg::*;
#(
  parameter int DATA_BITWIDTH = SPAD_DATA_W,
  parameter int ADDR_BITWIDTH = SPAD_ADDR_W,
  parameter int REP_BITWIDTH  = SPAD_REP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [ADDR_BITWIDTH:0]   i_cfg_len,
  input  logic [REP_BITWIDTH-1:0]  i_cfg_repeat,
  input  logic                     i_fill_valid,
  output logic                     o_fill_ready,
  input  logic [DATA_BITWIDTH-1:0] i_fill_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [DATA_BITWIDTH-1:0] o_rd_data,
  output logic                     o_rd_pass_last,
  output logic                     o_rd_last,
  output logic                     o_spad_wen,
  output logic [ADDR_BITWIDTH-1:0] o_spad_waddr,
  output logic [DATA_BITWIDTH-1:0] o_spad_wdata,
  output logic                     o_spad_ren,
  output logic [ADDR_BITWIDTH-1:0] o_spad_raddr,
  input  logic [DATA_BITWIDTH-1:0] i_spad_rdata,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int                    LW      = ADDR_BITWIDTH + 1;
  localparam int                    EW      = DATA_BITWIDTH + 2;
  localparam logic [LW-1:0]         MAX_LEN = LW'(1) << ADDR_BITWIDTH;
  localparam logic [LW-1:0]         LEN_ONE = LW'(1);
  localparam logic [REP_BITWIDTH-1:0] REP_ONE = REP_BITWIDTH'(1);

  spad_state_e             r_state;
  logic [LW-1:0]           r_len;
  logic [LW-1:0]           r_wcnt;
  logic [LW-1:0]           r_raddr;
  logic [REP_BITWIDTH-1:0] r_rep;
  logic [REP_BITWIDTH-1:0] r_pass;
  logic                    r_issue_done;
  logic                    r_inflight;
  logic                    r_infl_pass_last;
  logic                    r_infl_last;

  logic [LW-1:0] w_len_sat;
  logic [LW-1:0] w_len_m1;
  logic          w_fill_acc;
  logic          w_pop;
  logic          w_ren;
  logic          w_tag_pass_last;
  logic          w_tag_last;
  logic          w_drained;
  logic [2:0]    w_level;
  logic [2:0]    w_limit;
  logic [1:0]    w_occ;
  logic [EW-1:0] w_head;

  assign w_len_sat  = (i_cfg_len > MAX_LEN) ? MAX_LEN : i_cfg_len;
  assign w_len_m1   = r_len - LEN_ONE;
  assign w_fill_acc = (r_state == ST_FILL) && i_fill_valid;
  assign w_pop      = (w_occ != 2'd0) && i_rd_ready;

  // Issue only if the word can land in the skid buffer: buffered plus in flight, minus
  // what leaves this cycle, must leave a free slot. The ready->ren path is deliberate.
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_limit = 3'd1 + {2'b00, w_pop};
  assign w_ren   = (r_state == ST_READ) && !r_issue_done && (w_level <= w_limit);

  assign w_tag_pass_last = (r_raddr == w_len_m1);
  assign w_tag_last      = w_tag_pass_last && (r_pass == (r_rep - REP_ONE));

  // Everything issued has been delivered once the current pop empties the buffer.
  assign w_drained = r_issue_done && !r_inflight && (w_occ == {1'b0, w_pop});

  // Control FSM with length/repeat latching and fill/read address counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_rep        <= '0;
      r_wcnt       <= '0;
      r_raddr      <= '0;
      r_pass       <= '0;
      r_issue_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_len        <= w_len_sat;
            r_rep        <= i_cfg_repeat;
            r_wcnt       <= '0;
            r_raddr      <= '0;
            r_pass       <= '0;
            r_issue_done <= 1'b0;
            r_state      <= (w_len_sat == '0) ? ST_DONE : ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_fill_acc) begin
            r_wcnt <= r_wcnt + LEN_ONE;
            if (r_wcnt == w_len_m1) begin
              r_state <= (r_rep == '0) ? ST_DONE : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (w_ren) begin
            if (w_tag_pass_last) begin
              r_raddr <= '0;
              r_pass  <= r_pass + REP_ONE;
              if (w_tag_last) begin
                r_issue_done <= 1'b1;
              end
            end else begin
              r_raddr <= r_raddr + LEN_ONE;
            end
          end
          if (w_drained) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Track the read issued last cycle together with its tags, so its data can be captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight       <= 1'b0;
      r_infl_pass_last <= 1'b0;
      r_infl_last      <= 1'b0;
    end else begin
      r_inflight       <= w_ren;
      r_infl_pass_last <= w_ren && w_tag_pass_last;
      r_infl_last      <= w_ren && w_tag_last;
    end
  end

  spad_rd_skid #(
    .W (EW)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_push_data ({i_spad_rdata, r_infl_pass_last, r_infl_last}),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (w_head)
  );

  assign o_fill_ready   = (r_state == ST_FILL);
  assign o_spad_wen     = w_fill_acc;
  assign o_spad_waddr   = w_fill_acc ? r_wcnt[ADDR_BITWIDTH-1:0] : '0;
  assign o_spad_wdata   = w_fill_acc ? i_fill_data : '0;
  assign o_spad_ren     = w_ren;
  assign o_spad_raddr   = w_ren ? r_raddr[ADDR_BITWIDTH-1:0] : '0;
  assign o_rd_valid     = (w_occ != 2'd0);
  assign o_rd_data      = o_rd_valid ? w_head[EW-1:2] : '0;
  assign o_rd_pass_last = o_rd_valid && w_head[1];
  assign o_rd_last      = o_rd_valid && w_head[0];
  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_spad_seq.sv
// tb/tb_spad_seq.sv - directed self-checking bench for spad_seq
`timescale 1ns/1ps
module tb_spad_seq;
  import spad_pkg::*;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int RW = 8;

  logic          clk;
  logic          reset;
  logic          i_start;
  logic [AW:0]   i_cfg_len;
  logic [RW-1:0] i_cfg_repeat;
  logic          i_fill_valid;
  logic          o_fill_ready;
  logic [DW-1:0] i_fill_data;
  logic          o_rd_valid;
  logic          i_rd_ready;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_pass_last;
  logic          o_rd_last;
  logic          o_spad_wen;
  logic [AW-1:0] o_spad_waddr;
  logic [DW-1:0] o_spad_wdata;
  logic          o_spad_ren;
  logic [AW-1:0] o_spad_raddr;
  logic [DW-1:0] i_spad_rdata;
  logic          o_busy;
  logic          o_done;
  logic [57:0]   all_out;

  int total = 0;
  int bad   = 0;

  spad_seq #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .REP_BITWIDTH(RW)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_cfg_len(i_cfg_len),
    .i_cfg_repeat(i_cfg_repeat), .i_fill_valid(i_fill_valid), .o_fill_ready(o_fill_ready),
    .i_fill_data(i_fill_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_rd_data(o_rd_data), .o_rd_pass_last(o_rd_pass_last), .o_rd_last(o_rd_last),
    .o_spad_wen(o_spad_wen), .o_spad_waddr(o_spad_waddr), .o_spad_wdata(o_spad_wdata),
    .o_spad_ren(o_spad_ren), .o_spad_raddr(o_spad_raddr), .i_spad_rdata(i_spad_rdata),
    .o_busy(o_busy), .o_done(o_done)
  );

  assign all_out = {o_fill_ready, o_rd_valid, o_rd_data, o_rd_pass_last, o_rd_last, o_spad_wen,
                    o_spad_waddr, o_spad_wdata, o_spad_ren, o_spad_raddr, o_busy, o_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratchpad model: synchronous write, 1-cycle read, zero data when not read.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (o_spad_wen) mem[o_spad_waddr] <= o_spad_wdata;
    i_spad_rdata <= o_spad_ren ? mem[o_spad_raddr] : '0;
  end

  // Occupancy model rebuilt from the ports: no overflow, valid matches model, no over-issue.
  int   m_occ = 0;
  logic m_infl = 1'b0;
  always @(negedge clk) begin
    if (!reset || !o_busy) begin
      m_occ  = 0;
      m_infl = 1'b0;
    end else begin
      total++;
      if (o_rd_valid !== (m_occ != 0)) begin
        bad++;
        $display("FAIL mon_valid t=%0t got=%b exp=%b", $time, o_rd_valid, (m_occ != 0));
      end
      total++;
      if (m_occ > 2) begin
        bad++;
        $display("FAIL mon_occ t=%0t got=%0d exp<=2", $time, m_occ);
      end
      total++;
      if (o_spad_ren === 1'b1 && (m_occ + int'(m_infl)) == 2 && !(o_rd_valid && i_rd_ready)) begin
        bad++;
        $display("FAIL mon_overissue t=%0t ren=1 occ=%0d infl=%0d exp ren=0", $time, m_occ, m_infl);
      end
      m_occ  = m_occ + int'(m_infl) - int'(o_rd_valid && i_rd_ready);
      m_infl = o_spad_ren;
    end
  end

  skid_entry_t   rd_q[$];
  int            rd_cyc_q[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            ren_cnt, done_cyc, done_cnt, last_acc, stab_bad, timed_out;
  logic          busy_after;

  // Start a job, feed the fill stream, drive ready (mode 0: always, mode 1: 1,0,0 repeating)
  // and record everything seen; abort_after>0 returns right after that many reads.
  task automatic run_job(input int len, input int rep, input int nfill, input int base,
                         input int mode, input int abort_after);
    int          fill_idx;
    logic        prev_stall;
    logic [DW+1:0] prev_out, cur_out;
    skid_entry_t e;
    rd_q.delete(); rd_cyc_q.delete(); wa_q.delete(); wd_q.delete();
    ren_cnt = 0; done_cyc = -1; done_cnt = 0; last_acc = -1; stab_bad = 0;
    timed_out = 1; busy_after = 1'b1; fill_idx = 0; prev_stall = 1'b0; prev_out = '0;
    @(posedge clk); #1;
    i_start = 1'b1; i_cfg_len = (AW+1)'(len); i_cfg_repeat = RW'(rep);
    i_fill_valid = 1'b0; i_rd_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int c = 1; c < 4000; c++) begin
      i_fill_valid = (fill_idx < nfill);
      i_fill_data  = DW'(base + fill_idx);
      i_rd_ready   = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      @(negedge clk);
      cur_out = {o_rd_data, o_rd_pass_last, o_rd_last};
      if (prev_stall && (!o_rd_valid || cur_out !== prev_out)) stab_bad++;
      prev_stall = o_rd_valid && !i_rd_ready;
      prev_out   = cur_out;
      if (i_fill_valid && o_fill_ready) fill_idx++;
      if (o_spad_wen) begin wa_q.push_back(o_spad_waddr); wd_q.push_back(o_spad_wdata); end
      if (o_spad_ren) ren_cnt++;
      if (o_rd_valid && i_rd_ready) begin
        e.data = o_rd_data; e.pass_last = o_rd_pass_last; e.last = o_rd_last;
        rd_q.push_back(e); rd_cyc_q.push_back(c); last_acc = c;
      end
      if (o_done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (abort_after > 0 && rd_q.size() == abort_after) begin timed_out = 0; return; end
      if (done_cyc >= 0 && c == done_cyc + 1) begin busy_after = o_busy; timed_out = 0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; i_cfg_len = '0; i_cfg_repeat = '0;
    i_fill_valid = 1'b0; i_fill_data = '0; i_rd_ready = 1'b0;
    #2 reset = 1'b0;
    #10;
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
  endtask

  task automatic check_replay4(input string tag);
    skid_entry_t ex;
    total++;
    if (timed_out != 0) begin bad++; $display("FAIL %s_timeout got=timeout exp=done", tag); end
    total++;
    if (rd_q.size() != 8) begin bad++; $display("FAIL %s_rd_count got=%0d exp=8", tag, rd_q.size()); end
    for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
      ex.data = DW'(16'hA0 + (i % 4)); ex.pass_last = ((i % 4) == 3); ex.last = (i == 7);
      total++;
      if (rd_q[i] !== ex) begin bad++; $display("FAIL %s_rd%0d got=%h exp=%h", tag, i, rd_q[i], ex); end
    end
    total++;
    if (ren_cnt != 8) begin bad++; $display("FAIL %s_ren_count got=%0d exp=8", tag, ren_cnt); end
    total++;
    if (done_cnt != 1 || done_cyc != last_acc + 1) begin
      bad++; $display("FAIL %s_done got=cyc%0d/n%0d exp=cyc%0d/n1", tag, done_cyc, done_cnt, last_acc + 1);
    end
  endtask

  task automatic test_basic();
    run_job(4, 2, 4, 'hA0, 0, 0);
    check_replay4("basic");
    total++;
    if (wa_q.size() != 4) begin bad++; $display("FAIL basic_wr_count got=%0d exp=4", wa_q.size()); end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      total++;
      if (wa_q[i] !== AW'(i) || wd_q[i] !== DW'(16'hA0 + i)) begin
        bad++; $display("FAIL basic_wr%0d got=%0d:%h exp=%0d:%h", i, wa_q[i], wd_q[i], i, 16'hA0 + i);
      end
    end
    total++;
    if (rd_cyc_q.size() != 8 || rd_cyc_q[0] != 7 || rd_cyc_q[7] != 14) begin
      bad++; $display("FAIL basic_rd_timing got=n%0d exp=cycles 7..14", rd_cyc_q.size());
    end
    total++;
    if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy_after); end
  endtask

  task automatic test_backpressure();
    run_job(4, 2, 4, 'hA0, 1, 0);
    check_replay4("bp");
    total++;
    if (stab_bad != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_bad); end
  endtask

  task automatic test_len_zero();
    run_job(0, 3, 0, 0, 0, 0);
    total++;
    if (timed_out != 0 || done_cyc != 1 || done_cnt != 1) begin
      bad++; $display("FAIL len0_done got=cyc%0d/n%0d exp=cyc1/n1", done_cyc, done_cnt);
    end
    total++;
    if (wa_q.size() != 0 || ren_cnt != 0 || rd_q.size() != 0) begin
      bad++; $display("FAIL len0_quiet got=w%0d/r%0d/d%0d exp=0/0/0", wa_q.size(), ren_cnt, rd_q.size());
    end
    total++;
    if (busy_after !== 1'b0) begin bad++; $display("FAIL len0_busy got=%b exp=0", busy_after); end
  endtask

  task automatic test_repeat_zero();
    run_job(3, 0, 3, 1, 0, 0);
    total++;
    if (wa_q.size() != 3) begin bad++; $display("FAIL rep0_wr_count got=%0d exp=3", wa_q.size()); end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      total++;
      if (wa_q[i] !== AW'(i) || wd_q[i] !== DW'(i + 1)) begin
        bad++; $display("FAIL rep0_wr%0d got=%0d:%0d exp=%0d:%0d", i, wa_q[i], wd_q[i], i, i + 1);
      end
    end
    total++;
    if (ren_cnt != 0 || rd_q.size() != 0) begin
      bad++; $display("FAIL rep0_no_read got=ren%0d/rd%0d exp=0/0", ren_cnt, rd_q.size());
    end
    total++;
    if (timed_out != 0 || done_cyc != 4 || done_cnt != 1) begin
      bad++; $display("FAIL rep0_done got=cyc%0d/n%0d exp=cyc4/n1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_len_max(input int len);
    int wr_err, rd_err;
    run_job(len, 1, 512, 0, 0, 0);
    wr_err = 0; rd_err = 0;
    for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] !== AW'(i) || wd_q[i] !== DW'(i)) wr_err++;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i].data !== DW'(i)) rd_err++;
    total++;
    if (wa_q.size() != 512 || wr_err != 0) begin
      bad++; $display("FAIL max%0d_writes got=n%0d/err%0d exp=n512/err0", len, wa_q.size(), wr_err);
    end
    total++;
    if (rd_q.size() != 512 || rd_err != 0) begin
      bad++; $display("FAIL max%0d_reads got=n%0d/err%0d exp=n512/err0", len, rd_q.size(), rd_err);
    end
    total++;
    if (rd_q.size() != 512 || rd_q[511].pass_last !== 1'b1 || rd_q[511].last !== 1'b1
        || rd_q[510].pass_last !== 1'b0) begin
      bad++; $display("FAIL max%0d_tags got=n%0d exp=tags only on word 512", len, rd_q.size());
    end
    total++;
    if (timed_out != 0 || done_cyc != 1027) begin
      bad++; $display("FAIL max%0d_done got=cyc%0d exp=cyc1027", len, done_cyc);
    end
  endtask

  task automatic test_reset_mid_read();
    skid_entry_t ex;
    run_job(4, 2, 4, 'hA0, 0, 5);
    total++;
    if (timed_out != 0 || o_busy !== 1'b1 || o_rd_valid !== 1'b1) begin
      bad++; $display("FAIL midrd_pre got=busy%b/valid%b exp=1/1", o_busy, o_rd_valid);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL midrd_async_outputs got=%h exp=0", all_out); end
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL midrd_busy got=%b exp=0", o_busy); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_job(2, 1, 2, 'h55, 0, 0);
    total++;
    if (timed_out != 0 || rd_q.size() != 2 || done_cnt != 1) begin
      bad++; $display("FAIL post_rst_job got=n%0d/done%0d exp=n2/done1", rd_q.size(), done_cnt);
    end
    for (int i = 0; i < 2 && i < rd_q.size(); i++) begin
      ex.data = DW'(16'h55 + i); ex.pass_last = (i == 1); ex.last = (i == 1);
      total++;
      if (rd_q[i] !== ex) begin bad++; $display("FAIL post_rst_rd%0d got=%h exp=%h", i, rd_q[i], ex); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=no finish exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_repeat_zero();
    test_len_max(512);
    test_len_max(600);
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
